rx_pkt_payload_queue: RTL and testbench
=======================================

Name: rx_pkt_payload_queue

Overview:
- Per-flow circular receive-payload descriptor queues for the TCP RX path.
- Stores head/tail pointers per flow ID, each with one extra wrap bit, plus a payload-descriptor buffer per flow.
- Serves four clients: pointer initialisation, queue-state (full-check) lookup, packet enqueue at a caller-supplied tail index, and head dequeue with empty indication.

Parameters:
- FLOW_ID_W, 2, flow ID width; NUM_FLOWS = 2**FLOW_ID_W.
- RX_PAYLOAD_Q_SIZE_W, 3, log2 of entries per flow; pointers are RX_PAYLOAD_Q_SIZE_W+1 bits wide (PW).
- PAYLOAD_ENTRY_W, 64, payload descriptor width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- new_head_val/new_head_rdy  in/out  1/1  head pointer write handshake
- new_head_addr  in  FLOW_ID_W  flow to write; new_head_data  in  PW  new head value
- new_tail_val/new_tail_rdy  in/out  1/1  tail pointer write handshake
- new_tail_addr  in  FLOW_ID_W  flow to write; new_tail_data  in  PW  new tail value
- q_full_req_val/q_full_req_rdy  in/out  1/1  state lookup request
- q_full_req_flowid  in  FLOW_ID_W  flow to look up
- q_full_resp_val/q_full_resp_rdy  out/in  1/1  state lookup response
- q_full_resp_head_index  out  PW  head pointer; q_full_resp_tail_index  out  PW  tail pointer
- enqueue_pkt_req_val/enqueue_pkt_req_rdy  in/out  1/1  enqueue handshake
- enqueue_pkt_req_flowid  in  FLOW_ID_W  flow; enqueue_pkt_req_data  in  PAYLOAD_ENTRY_W  descriptor; enqueue_pkt_req_index  in  PW  slot (current tail)
- read_payload_req_val/read_payload_req_rdy  in/out  1/1  dequeue request
- read_payload_req_flowid  in  FLOW_ID_W  flow to dequeue
- read_payload_resp_val/read_payload_resp_rdy  out/in  1/1  dequeue response
- read_payload_resp_is_empty  out  1  queue was empty; read_payload_resp_entry  out  PAYLOAD_ENTRY_W  dequeued descriptor

Behaviour:
- Reset (rst low, async): all head and tail pointers 0; both response valids 0; response data registers 0. The payload buffer is not reset.
- Transfer on val&rdy at posedge clk.
- new_head_rdy = new_tail_rdy = 1 always. An accepted write sets head[addr] or tail[addr] next cycle. Head and tail writes are independent; both may occur in the same cycle.
- enqueue_pkt_req_rdy = ~new_tail_val.
- Enqueue accepted: buf[flowid][index[Q-1:0]] <= data and tail[flowid] <= index+1, mod 2**PW.
- Enqueue performs no full check; the requester checks fullness via the lookup first. Enqueue into a full queue overwrites the slot.
- Full iff head[Q-1:0]==tail[Q-1:0] and the wrap bits differ. Empty iff head==tail (all PW bits).
- q_full_req_rdy = ~q_full_resp_val | q_full_resp_rdy.
- Lookup accepted: head[flowid] and tail[flowid] are registered into the response; q_full_resp_val rises next cycle. Response data and valid are held stable until q_full_resp_rdy.
- read_payload_req_rdy = ~new_head_val & (~read_payload_resp_val | read_payload_resp_rdy).
- Dequeue accepted, head!=tail: response carries is_empty=0 and entry=buf[flowid][head[Q-1:0]]; head[flowid] <= head+1, mod 2**PW.
- Dequeue accepted, head==tail: response carries is_empty=1 and entry=0; head unchanged.
- Dequeue response appears the cycle after acceptance and is held until read_payload_resp_rdy.
- Latency is 1 cycle for both response channels. Full throughput of one request per cycle per channel when the consumer is ready.
- All lookups and dequeues read pointer and buffer state before same-cycle updates. Example: an enqueue and a dequeue on the same empty flow in the same cycle return is_empty=1, and the entry becomes visible next cycle.
- Simultaneous new_tail write and enqueue: blocked by enqueue rdy. Simultaneous new_head write and dequeue: blocked by dequeue rdy.
- Different flows never interact.
- Pointer wrap: 2**PW-1 + 1 = 0.
- Reset mid-operation clears pointers and drops pending responses.

Test Plan:
- Reset, then lookup flow 1 -> one cycle later q_full_resp head=0, tail=0.
- new head=0/tail=0 on flow 2; enqueue flow 2 index 0 data 0xAAAA; lookup flow 2 -> head=0, tail=1. Dequeue flow 2 -> is_empty=0, entry=0xAAAA. Dequeue again -> is_empty=1; lookup -> head=1, tail=1.
- Enqueue 8 entries (0x10..0x17) to flow 0 at indices 0..7 -> lookup gives head=0, tail=8 (full). Eight dequeues return 0x10..0x17 in order; the ninth returns is_empty=1.
- Wrap: new head=14/tail=14 on flow 3; enqueue at 14 (0x1) and 15 (0x2) -> tail=0. Dequeues return 0x1 then 0x2; head=0; next dequeue is empty.
- Backpressure: hold read_payload_resp_rdy=0 after one dequeue -> resp stays valid and stable, read_payload_req_rdy=0. Release -> response consumed and the next request accepted the same cycle.
- Flow isolation and priority: enqueue flow 1 while new_tail_val on flow 1 -> enqueue stalled one cycle. Flow 0 pointers unchanged by any flow 1 activity.

Source files
------------

// File: rtl/rx_pkt_payload_queue.sv
// rx_pkt_payload_queue
//
// Purpose:
//   Per-flow circular receive-payload descriptor queues for the TCP RX path.
//   Each flow has a head pointer, a tail pointer and a small descriptor buffer.
//   Pointers carry one extra wrap bit beyond the slot index. That lets a full
//   queue be told apart from an empty one:
//     empty : head == tail
//     full  : head[Q-1:0] == tail[Q-1:0] and the wrap bits differ
//
// Port summary:
//   clk, rst                        clock, asynchronous active-low reset
//   new_head_*                      head pointer write (always ready)
//   new_tail_*                      tail pointer write (always ready)
//   q_full_req_* / q_full_resp_*    head/tail lookup, 1-cycle registered response
//   enqueue_pkt_req_*               descriptor write at a caller-supplied tail slot
//   read_payload_req_* / _resp_*    head dequeue, 1-cycle registered response
//                                   with an empty indication
//
// All lookups and dequeues read pointer and buffer state as it was before the
// updates of the same cycle.

module rx_pkt_payload_queue #(
  parameter int FLOW_ID_W           = 2,
  parameter int RX_PAYLOAD_Q_SIZE_W = 3,
  parameter int PAYLOAD_ENTRY_W     = 64
) (
  input  logic                           clk,
  input  logic                           rst,

  // Head pointer write
  input  logic                           new_head_val_i,
  output logic                           new_head_rdy_o,
  input  logic [FLOW_ID_W-1:0]           new_head_addr_i,
  input  logic [RX_PAYLOAD_Q_SIZE_W:0]   new_head_data_i,

  // Tail pointer write
  input  logic                           new_tail_val_i,
  output logic                           new_tail_rdy_o,
  input  logic [FLOW_ID_W-1:0]           new_tail_addr_i,
  input  logic [RX_PAYLOAD_Q_SIZE_W:0]   new_tail_data_i,

  // Queue-state lookup
  input  logic                           q_full_req_val_i,
  output logic                           q_full_req_rdy_o,
  input  logic [FLOW_ID_W-1:0]           q_full_req_flowid_i,
  output logic                           q_full_resp_val_o,
  input  logic                           q_full_resp_rdy_i,
  output logic [RX_PAYLOAD_Q_SIZE_W:0]   q_full_resp_head_index_o,
  output logic [RX_PAYLOAD_Q_SIZE_W:0]   q_full_resp_tail_index_o,

  // Enqueue
  input  logic                           enqueue_pkt_req_val_i,
  output logic                           enqueue_pkt_req_rdy_o,
  input  logic [FLOW_ID_W-1:0]           enqueue_pkt_req_flowid_i,
  input  logic [PAYLOAD_ENTRY_W-1:0]     enqueue_pkt_req_data_i,
  input  logic [RX_PAYLOAD_Q_SIZE_W:0]   enqueue_pkt_req_index_i,

  // Dequeue
  input  logic                           read_payload_req_val_i,
  output logic                           read_payload_req_rdy_o,
  input  logic [FLOW_ID_W-1:0]           read_payload_req_flowid_i,
  output logic                           read_payload_resp_val_o,
  input  logic                           read_payload_resp_rdy_i,
  output logic                           read_payload_resp_is_empty_o,
  output logic [PAYLOAD_ENTRY_W-1:0]     read_payload_resp_entry_o
);

  localparam int NUM_FLOWS = 2 ** FLOW_ID_W;
  localparam int Q         = RX_PAYLOAD_Q_SIZE_W;
  localparam int DEPTH     = 2 ** Q;
  localparam int PW        = Q + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]              headPtr_q [NUM_FLOWS];
  logic [PW-1:0]              headPtr_d [NUM_FLOWS];
  logic [PW-1:0]              tailPtr_q [NUM_FLOWS];
  logic [PW-1:0]              tailPtr_d [NUM_FLOWS];

  logic [PAYLOAD_ENTRY_W-1:0] payloadBuf_q [NUM_FLOWS][DEPTH];

  logic                       fullRespVal_q;
  logic                       fullRespVal_d;
  logic [PW-1:0]              fullRespHead_q;
  logic [PW-1:0]              fullRespHead_d;
  logic [PW-1:0]              fullRespTail_q;
  logic [PW-1:0]              fullRespTail_d;

  logic                       readRespVal_q;
  logic                       readRespVal_d;
  logic                       readRespEmpty_q;
  logic                       readRespEmpty_d;
  logic [PAYLOAD_ENTRY_W-1:0] readRespEntry_q;
  logic [PAYLOAD_ENTRY_W-1:0] readRespEntry_d;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic newHeadFire;
  logic newTailFire;
  logic fullReqFire;
  logic enqFire;
  logic deqFire;

  // A pointer write from software takes priority over an enqueue or dequeue
  // to the same pointer, so the queue side is stalled while a write is
  // offered. This means each pointer has at most one writer per cycle.
  assign new_head_rdy_o         = 1'b1;
  assign new_tail_rdy_o         = 1'b1;
  assign enqueue_pkt_req_rdy_o  = ~new_tail_val_i;
  assign q_full_req_rdy_o       = ~fullRespVal_q | q_full_resp_rdy_i;
  assign read_payload_req_rdy_o = ~new_head_val_i &
                                  (~readRespVal_q | read_payload_resp_rdy_i);

  assign newHeadFire = new_head_val_i;
  assign newTailFire = new_tail_val_i;
  assign fullReqFire = q_full_req_val_i & q_full_req_rdy_o;
  assign enqFire     = enqueue_pkt_req_val_i & enqueue_pkt_req_rdy_o;
  assign deqFire     = read_payload_req_val_i & read_payload_req_rdy_o;

  // --------------------------------------------------------------------------
  // Dequeue read path (pre-update state)
  // --------------------------------------------------------------------------
  logic [PW-1:0]              deqHead;
  logic [PW-1:0]              deqTail;
  logic                       deqIsEmpty;
  logic [PAYLOAD_ENTRY_W-1:0] deqEntry;

  assign deqHead    = headPtr_q[read_payload_req_flowid_i];
  assign deqTail    = tailPtr_q[read_payload_req_flowid_i];
  assign deqIsEmpty = (deqHead == deqTail);
  assign deqEntry   = payloadBuf_q[read_payload_req_flowid_i][deqHead[Q-1:0]];

  // --------------------------------------------------------------------------
  // Pointer next-state
  // --------------------------------------------------------------------------
  // Increments rely on natural PW-bit wraparound, so the wrap bit toggles
  // each time a pointer passes the last slot.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;

    if (newHeadFire) begin
      headPtr_d[new_head_addr_i] = new_head_data_i;
    end
    if (deqFire && !deqIsEmpty) begin
      headPtr_d[read_payload_req_flowid_i] = deqHead + PW'(1);
    end

    if (newTailFire) begin
      tailPtr_d[new_tail_addr_i] = new_tail_data_i;
    end
    if (enqFire) begin
      tailPtr_d[enqueue_pkt_req_flowid_i] = enqueue_pkt_req_index_i + PW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Response next-state
  // --------------------------------------------------------------------------
  // A response is loaded on acceptance. It is cleared once consumed with no
  // replacement, and otherwise held unchanged.
  always_comb begin
    fullRespVal_d  = fullRespVal_q;
    fullRespHead_d = fullRespHead_q;
    fullRespTail_d = fullRespTail_q;

    if (fullReqFire) begin
      fullRespVal_d  = 1'b1;
      fullRespHead_d = headPtr_q[q_full_req_flowid_i];
      fullRespTail_d = tailPtr_q[q_full_req_flowid_i];
    end else if (q_full_resp_rdy_i) begin
      fullRespVal_d  = 1'b0;
    end
  end

  // An empty dequeue returns a zero entry rather than a stale buffer slot.
  always_comb begin
    readRespVal_d   = readRespVal_q;
    readRespEmpty_d = readRespEmpty_q;
    readRespEntry_d = readRespEntry_q;

    if (deqFire) begin
      readRespVal_d   = 1'b1;
      readRespEmpty_d = deqIsEmpty;
      readRespEntry_d = deqIsEmpty ? '0 : deqEntry;
    end else if (read_payload_resp_rdy_i) begin
      readRespVal_d   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Pointers and both response channels. A reset also drops any pending
  // response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        headPtr_q[f] <= '0;
        tailPtr_q[f] <= '0;
      end
      fullRespVal_q   <= 1'b0;
      fullRespHead_q  <= '0;
      fullRespTail_q  <= '0;
      readRespVal_q   <= 1'b0;
      readRespEmpty_q <= 1'b0;
      readRespEntry_q <= '0;
    end else begin
      headPtr_q       <= headPtr_d;
      tailPtr_q       <= tailPtr_d;
      fullRespVal_q   <= fullRespVal_d;
      fullRespHead_q  <= fullRespHead_d;
      fullRespTail_q  <= fullRespTail_d;
      readRespVal_q   <= readRespVal_d;
      readRespEmpty_q <= readRespEmpty_d;
      readRespEntry_q <= readRespEntry_d;
    end
  end

  // The payload buffer has no reset. A slot is only meaningful once the
  // pointers say it has been written. There is no full check here: writing
  // into a full queue overwrites the slot.
  always_ff @(posedge clk) begin
    if (enqFire) begin
      payloadBuf_q[enqueue_pkt_req_flowid_i][enqueue_pkt_req_index_i[Q-1:0]]
        <= enqueue_pkt_req_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign q_full_resp_val_o            = fullRespVal_q;
  assign q_full_resp_head_index_o     = fullRespHead_q;
  assign q_full_resp_tail_index_o     = fullRespTail_q;
  assign read_payload_resp_val_o      = readRespVal_q;
  assign read_payload_resp_is_empty_o = readRespEmpty_q;
  assign read_payload_resp_entry_o    = readRespEntry_q;

endmodule

// File: tb/tb_rx_pkt_payload_queue.sv
// tb_rx_pkt_payload_queue
//
// Purpose:
//   Directed testbench for rx_pkt_payload_queue. It applies directed steps
//   and compares the outputs against hand-computed values.
//   Inputs change 1ns after the rising edge, and outputs are sampled there too.

module tb_rx_pkt_payload_queue;

  localparam int FLOW_ID_W = 2;
  localparam int QW        = 3;
  localparam int PW        = QW + 1;
  localparam int EW        = 64;

  logic            clk;
  logic            rst;
  logic            new_head_val_i;
  logic            new_head_rdy_o;
  logic [1:0]      new_head_addr_i;
  logic [PW-1:0]   new_head_data_i;
  logic            new_tail_val_i;
  logic            new_tail_rdy_o;
  logic [1:0]      new_tail_addr_i;
  logic [PW-1:0]   new_tail_data_i;
  logic            q_full_req_val_i;
  logic            q_full_req_rdy_o;
  logic [1:0]      q_full_req_flowid_i;
  logic            q_full_resp_val_o;
  logic            q_full_resp_rdy_i;
  logic [PW-1:0]   q_full_resp_head_index_o;
  logic [PW-1:0]   q_full_resp_tail_index_o;
  logic            enqueue_pkt_req_val_i;
  logic            enqueue_pkt_req_rdy_o;
  logic [1:0]      enqueue_pkt_req_flowid_i;
  logic [EW-1:0]   enqueue_pkt_req_data_i;
  logic [PW-1:0]   enqueue_pkt_req_index_i;
  logic            read_payload_req_val_i;
  logic            read_payload_req_rdy_o;
  logic [1:0]      read_payload_req_flowid_i;
  logic            read_payload_resp_val_o;
  logic            read_payload_resp_rdy_i;
  logic            read_payload_resp_is_empty_o;
  logic [EW-1:0]   read_payload_resp_entry_o;

  int compareCount = 0;
  int errCount     = 0;

  rx_pkt_payload_queue #(
    .FLOW_ID_W(FLOW_ID_W),
    .RX_PAYLOAD_Q_SIZE_W(QW),
    .PAYLOAD_ENTRY_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_head_val_i(new_head_val_i),
    .new_head_rdy_o(new_head_rdy_o),
    .new_head_addr_i(new_head_addr_i),
    .new_head_data_i(new_head_data_i),
    .new_tail_val_i(new_tail_val_i),
    .new_tail_rdy_o(new_tail_rdy_o),
    .new_tail_addr_i(new_tail_addr_i),
    .new_tail_data_i(new_tail_data_i),
    .q_full_req_val_i(q_full_req_val_i),
    .q_full_req_rdy_o(q_full_req_rdy_o),
    .q_full_req_flowid_i(q_full_req_flowid_i),
    .q_full_resp_val_o(q_full_resp_val_o),
    .q_full_resp_rdy_i(q_full_resp_rdy_i),
    .q_full_resp_head_index_o(q_full_resp_head_index_o),
    .q_full_resp_tail_index_o(q_full_resp_tail_index_o),
    .enqueue_pkt_req_val_i(enqueue_pkt_req_val_i),
    .enqueue_pkt_req_rdy_o(enqueue_pkt_req_rdy_o),
    .enqueue_pkt_req_flowid_i(enqueue_pkt_req_flowid_i),
    .enqueue_pkt_req_data_i(enqueue_pkt_req_data_i),
    .enqueue_pkt_req_index_i(enqueue_pkt_req_index_i),
    .read_payload_req_val_i(read_payload_req_val_i),
    .read_payload_req_rdy_o(read_payload_req_rdy_o),
    .read_payload_req_flowid_i(read_payload_req_flowid_i),
    .read_payload_resp_val_o(read_payload_resp_val_o),
    .read_payload_resp_rdy_i(read_payload_resp_rdy_i),
    .read_payload_resp_is_empty_o(read_payload_resp_is_empty_o),
    .read_payload_resp_entry_o(read_payload_resp_entry_o)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doEnqueue(input logic [1:0] flow, input logic [PW-1:0] idx,
                           input logic [EW-1:0] data);
    enqueue_pkt_req_val_i    = 1'b1;
    enqueue_pkt_req_flowid_i = flow;
    enqueue_pkt_req_index_i  = idx;
    enqueue_pkt_req_data_i   = data;
    applyStimulus();
    enqueue_pkt_req_val_i    = 1'b0;
  endtask

  task automatic doLookup(input string tag, input logic [1:0] flow,
                          input logic [PW-1:0] expHead, input logic [PW-1:0] expTail);
    q_full_req_val_i    = 1'b1;
    q_full_req_flowid_i = flow;
    applyStimulus();
    q_full_req_val_i    = 1'b0;
    checkOutput({tag, "_val"}, 64'(q_full_resp_val_o), 64'd1);
    checkOutput({tag, "_head"}, 64'(q_full_resp_head_index_o), 64'(expHead));
    checkOutput({tag, "_tail"}, 64'(q_full_resp_tail_index_o), 64'(expTail));
  endtask

  task automatic doDequeue(input string tag, input logic [1:0] flow,
                           input logic expEmpty, input logic [EW-1:0] expEntry);
    read_payload_req_val_i    = 1'b1;
    read_payload_req_flowid_i = flow;
    applyStimulus();
    read_payload_req_val_i    = 1'b0;
    checkOutput({tag, "_val"}, 64'(read_payload_resp_val_o), 64'd1);
    checkOutput({tag, "_empty"}, 64'(read_payload_resp_is_empty_o), 64'(expEmpty));
    checkOutput({tag, "_entry"}, read_payload_resp_entry_o, expEntry);
  endtask

  initial begin
    rst                       = 1'b0;
    new_head_val_i            = 1'b0;
    new_head_addr_i           = '0;
    new_head_data_i           = '0;
    new_tail_val_i            = 1'b0;
    new_tail_addr_i           = '0;
    new_tail_data_i           = '0;
    q_full_req_val_i          = 1'b0;
    q_full_req_flowid_i       = '0;
    q_full_resp_rdy_i         = 1'b1;
    enqueue_pkt_req_val_i     = 1'b0;
    enqueue_pkt_req_flowid_i  = '0;
    enqueue_pkt_req_data_i    = '0;
    enqueue_pkt_req_index_i   = '0;
    read_payload_req_val_i    = 1'b0;
    read_payload_req_flowid_i = '0;
    read_payload_resp_rdy_i   = 1'b1;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_fullval", 64'(q_full_resp_val_o), 64'd0);
    checkOutput("rst_readval", 64'(read_payload_resp_val_o), 64'd0);
    checkOutput("rst_entry", read_payload_resp_entry_o, 64'd0);
    checkOutput("rst_headrdy", 64'(new_head_rdy_o), 64'd1);
    checkOutput("rst_tailrdy", 64'(new_tail_rdy_o), 64'd1);
    rst = 1'b1;
    applyStimulus();

    doLookup("lk_f1_reset", 2'd1, 4'd0, 4'd0);

    // Basic enqueue/dequeue on flow 2, with head and tail writes in one cycle
    new_head_val_i  = 1'b1; new_head_addr_i = 2'd2; new_head_data_i = 4'd0;
    new_tail_val_i  = 1'b1; new_tail_addr_i = 2'd2; new_tail_data_i = 4'd0;
    applyStimulus();
    new_head_val_i  = 1'b0;
    new_tail_val_i  = 1'b0;
    doEnqueue(2'd2, 4'd0, 64'hAAAA);
    doLookup("lk_f2_a", 2'd2, 4'd0, 4'd1);
    doDequeue("dq_f2_a", 2'd2, 1'b0, 64'hAAAA);
    doDequeue("dq_f2_b", 2'd2, 1'b1, 64'h0);
    doLookup("lk_f2_b", 2'd2, 4'd1, 4'd1);

    // Fill flow 0 to full, then drain it
    for (int i = 0; i < 8; i++) doEnqueue(2'd0, 4'(i), 64'h10 + 64'(i));
    doLookup("lk_f0_full", 2'd0, 4'd0, 4'd8);
    for (int i = 0; i < 8; i++)
      doDequeue($sformatf("dq_f0_%0d", i), 2'd0, 1'b0, 64'h10 + 64'(i));
    doDequeue("dq_f0_empty", 2'd0, 1'b1, 64'h0);

    // Pointer wrap on flow 3
    new_head_val_i  = 1'b1; new_head_addr_i = 2'd3; new_head_data_i = 4'd14;
    new_tail_val_i  = 1'b1; new_tail_addr_i = 2'd3; new_tail_data_i = 4'd14;
    applyStimulus();
    new_head_val_i  = 1'b0;
    new_tail_val_i  = 1'b0;
    doEnqueue(2'd3, 4'd14, 64'h1);
    doEnqueue(2'd3, 4'd15, 64'h2);
    doLookup("lk_f3_wrap", 2'd3, 4'd14, 4'd0);
    doDequeue("dq_f3_a", 2'd3, 1'b0, 64'h1);
    doDequeue("dq_f3_b", 2'd3, 1'b0, 64'h2);
    doLookup("lk_f3_after", 2'd3, 4'd0, 4'd0);
    doDequeue("dq_f3_empty", 2'd3, 1'b1, 64'h0);

    // Backpressure on the dequeue response (flow 1)
    doEnqueue(2'd1, 4'd0, 64'h55);
    doEnqueue(2'd1, 4'd1, 64'h66);
    read_payload_resp_rdy_i = 1'b0;
    doDequeue("dq_bp_first", 2'd1, 1'b0, 64'h55);
    read_payload_req_val_i    = 1'b1;
    read_payload_req_flowid_i = 2'd1;
    #1;
    checkOutput("bp_reqrdy_low", 64'(read_payload_req_rdy_o), 64'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("bp_hold_val", 64'(read_payload_resp_val_o), 64'd1);
    checkOutput("bp_hold_entry", read_payload_resp_entry_o, 64'h55);
    read_payload_resp_rdy_i = 1'b1;
    #1;
    checkOutput("bp_reqrdy_high", 64'(read_payload_req_rdy_o), 64'd1);
    applyStimulus();
    read_payload_req_val_i = 1'b0;
    checkOutput("bp_next_val", 64'(read_payload_resp_val_o), 64'd1);
    checkOutput("bp_next_entry", read_payload_resp_entry_o, 64'h66);

    // A head write blocks a dequeue
    new_head_val_i  = 1'b1; new_head_addr_i = 2'd2; new_head_data_i = 4'd1;
    read_payload_req_val_i = 1'b1;
    #1;
    checkOutput("hd_blocks_deq", 64'(read_payload_req_rdy_o), 64'd0);
    read_payload_req_val_i = 1'b0;
    applyStimulus();
    new_head_val_i  = 1'b0;

    // A tail write stalls an enqueue on flow 1 for one cycle
    new_tail_val_i  = 1'b1; new_tail_addr_i = 2'd1; new_tail_data_i = 4'd5;
    enqueue_pkt_req_val_i    = 1'b1;
    enqueue_pkt_req_flowid_i = 2'd1;
    enqueue_pkt_req_index_i  = 4'd2;
    enqueue_pkt_req_data_i   = 64'h77;
    #1;
    checkOutput("tl_blocks_enq", 64'(enqueue_pkt_req_rdy_o), 64'd0);
    applyStimulus();
    new_tail_val_i = 1'b0;
    #1;
    checkOutput("enq_rdy_again", 64'(enqueue_pkt_req_rdy_o), 64'd1);
    applyStimulus();
    enqueue_pkt_req_val_i = 1'b0;
    doLookup("lk_f1_stall", 2'd1, 4'd2, 4'd3);
    doDequeue("dq_f1_stall", 2'd1, 1'b0, 64'h77);
    doLookup("lk_f0_iso", 2'd0, 4'd8, 4'd8);

    // Same-cycle enqueue and dequeue on empty flow 0 sees the old state
    enqueue_pkt_req_val_i    = 1'b1;
    enqueue_pkt_req_flowid_i = 2'd0;
    enqueue_pkt_req_index_i  = 4'd8;
    enqueue_pkt_req_data_i   = 64'h99;
    doDequeue("dq_same_cycle", 2'd0, 1'b1, 64'h0);
    enqueue_pkt_req_val_i    = 1'b0;
    doDequeue("dq_after_same", 2'd0, 1'b0, 64'h99);

    // Asynchronous reset mid-operation drops a held response
    q_full_resp_rdy_i = 1'b0;
    doLookup("lk_pre_rst", 2'd3, 4'd0, 4'd0);
    rst = 1'b0;
    #1;
    checkOutput("arst_fullval", 64'(q_full_resp_val_o), 64'd0);
    applyStimulus();
    rst = 1'b1;
    q_full_resp_rdy_i = 1'b1;
    applyStimulus();
    doLookup("lk_f0_post_rst", 2'd0, 4'd0, 4'd0);

    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule
